ipdom_stack_mp: RTL and testbench

- Multi-warp immediate-post-dominator (divergence/reconvergence) stack for the warp scheduler's split/join path; successor to the single-port per-warp IPDOM stack.
- NUM_WARPS is a parameter rather than a global define. A push and a pop on different warps complete in the same cycle.
- Adds per-warp flush, per-warp occupancy counts, a registered pop-response channel and sticky error flags.
- "Taken" state lives in flops, so pointer updates never wait on the RAM read.

---
 rtl/ipdom_stack_mp.sv | 151 +++++++++++++++
 tb/tb_ipdom_stack_mp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ipdom_stack_mp.sv
// Multi-warp IPDOM divergence/reconvergence stack: one push and one pop per cycle
// on different warps, per-warp flush, registered pop responses and sticky error flags.
module ipdom_stack_mp #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int NUM_WARPS = 4,
    parameter int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_valid,
    input  logic [NW_WIDTH-1:0]       push_wid,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop_valid,
    input  logic [NW_WIDTH-1:0]       pop_wid,
    input  logic                      flush_valid,
    input  logic [NW_WIDTH-1:0]       flush_wid,
    output logic                      rsp_valid,
    output logic [NW_WIDTH-1:0]       rsp_wid,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_idx,
    output logic [NUM_WARPS-1:0]      empty,
    output logic [NUM_WARPS-1:0]      full,
    output logic [NUM_WARPS*CNTW-1:0] count,
    output logic                      err_overflow,
    output logic                      err_underflow,
    output logic                      err_conflict
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = (NUM_WARPS * DEPTH > 1) ? $clog2(NUM_WARPS * DEPTH) : 1;

    logic [WIDTH-1:0] mem [NUM_WARPS*DEPTH];

    logic [CNTW-1:0]  count_q [NUM_WARPS];
    logic [CNTW-1:0]  count_d [NUM_WARPS];
    logic [DEPTH-1:0] taken_q [NUM_WARPS];
    logic [DEPTH-1:0] taken_d [NUM_WARPS];

    logic                rsp_valid_q;
    logic [NW_WIDTH-1:0] rsp_wid_q;
    logic [WIDTH-1:0]    rsp_data_q;
    logic                rsp_idx_q;
    logic                err_overflow_q;
    logic                err_underflow_q;
    logic                err_conflict_q;

    logic          push_hit, pop_hit, conflict_evt;
    logic          push_accept, pop_accept;
    logic          overflow_evt, underflow_evt;
    logic [SW-1:0] push_slot, pop_slot;
    logic          pop_taken;
    logic [AW-1:0] wr_addr, rd_addr;

    // Flush wins over push/pop to the same warp without raising any error.
    assign push_hit     = push_valid && !(flush_valid && flush_wid == push_wid);
    assign pop_hit      = pop_valid && !(flush_valid && flush_wid == pop_wid);
    assign conflict_evt = pop_hit && push_hit && (push_wid == pop_wid);

    assign push_accept   = push_hit && !full[push_wid];
    assign overflow_evt  = push_hit && full[push_wid];
    assign pop_accept    = pop_hit && !conflict_evt && !empty[pop_wid];
    assign underflow_evt = pop_hit && !conflict_evt && empty[pop_wid];

    assign push_slot = SW'(count_q[push_wid]);
    assign pop_slot  = SW'(count_q[pop_wid] - CNTW'(1));
    assign pop_taken = taken_q[pop_wid][pop_slot];

    // Slot-major address, equal to {slot, wid} when NUM_WARPS is a power of two.
    assign wr_addr = AW'(int'(push_slot) * NUM_WARPS + int'(push_wid));
    assign rd_addr = AW'(int'(pop_slot) * NUM_WARPS + int'(pop_wid));

    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            count_d[w] = count_q[w];
            taken_d[w] = taken_q[w];
            if (flush_valid && flush_wid == NW_WIDTH'(w)) begin
                count_d[w] = '0;
                taken_d[w] = '0;
            end else begin
                if (push_accept && push_wid == NW_WIDTH'(w)) begin
                    taken_d[w][push_slot] = 1'b0;
                    count_d[w]            = count_q[w] + CNTW'(1);
                end
                // First pop of an entry marks it taken; the second removes it.
                if (pop_accept && pop_wid == NW_WIDTH'(w)) begin
                    if (!pop_taken) begin
                        taken_d[w][pop_slot] = 1'b1;
                    end else begin
                        taken_d[w][pop_slot] = 1'b0;
                        count_d[w]           = count_q[w] - CNTW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= '0;
                taken_q[w] <= '0;
            end
            rsp_valid_q     <= 1'b0;
            rsp_wid_q       <= '0;
            rsp_data_q      <= '0;
            rsp_idx_q       <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_conflict_q  <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= count_d[w];
                taken_q[w] <= taken_d[w];
            end
            rsp_valid_q <= pop_accept;
            if (pop_accept) begin
                rsp_wid_q  <= pop_wid;
                rsp_data_q <= mem[rd_addr];
                rsp_idx_q  <= pop_taken;
            end
            if (overflow_evt)  err_overflow_q  <= 1'b1;
            if (underflow_evt) err_underflow_q <= 1'b1;
            if (conflict_evt)  err_conflict_q  <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_status
            assign empty[gi]                 = (count_q[gi] == '0);
            assign full[gi]                  = (count_q[gi] == CNTW'(DEPTH));
            assign count[gi*CNTW +: CNTW]    = count_q[gi];
        end
    endgenerate

    assign rsp_valid     = rsp_valid_q;
    assign rsp_wid       = rsp_wid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_idx       = rsp_idx_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign err_conflict  = err_conflict_q;

endmodule

// File: tb/tb_ipdom_stack_mp.sv
// Directed bench for ipdom_stack_mp: split/join ordering, overflow, dual-warp
// traffic, same-warp conflict, flush, underflow and reset of a pending response.
module tb_ipdom_stack_mp;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 8;
    localparam int NUM_WARPS = 4;
    localparam int NW_WIDTH  = 2;
    localparam int CNTW      = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      push_valid;
    logic [NW_WIDTH-1:0]       push_wid;
    logic [WIDTH-1:0]          push_data;
    logic                      pop_valid;
    logic [NW_WIDTH-1:0]       pop_wid;
    logic                      flush_valid;
    logic [NW_WIDTH-1:0]       flush_wid;
    logic                      rsp_valid;
    logic [NW_WIDTH-1:0]       rsp_wid;
    logic [WIDTH-1:0]          rsp_data;
    logic                      rsp_idx;
    logic [NUM_WARPS-1:0]      empty;
    logic [NUM_WARPS-1:0]      full;
    logic [NUM_WARPS*CNTW-1:0] count;
    logic                      err_overflow;
    logic                      err_underflow;
    logic                      err_conflict;

    int total = 0;
    int bad   = 0;

    ipdom_stack_mp #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WARPS(NUM_WARPS),
        .NW_WIDTH(NW_WIDTH), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_wid(push_wid), .push_data(push_data),
        .pop_valid(pop_valid), .pop_wid(pop_wid),
        .flush_valid(flush_valid), .flush_wid(flush_wid),
        .rsp_valid(rsp_valid), .rsp_wid(rsp_wid), .rsp_data(rsp_data), .rsp_idx(rsp_idx),
        .empty(empty), .full(full), .count(count),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid  = 1'b0;
        pop_valid   = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic do_push(input int w, input logic [WIDTH-1:0] d);
        idle();
        push_valid = 1'b1;
        push_wid   = NW_WIDTH'(w);
        push_data  = d;
        cyc();
        idle();
    endtask

    task automatic do_pop(input int w);
        idle();
        pop_valid = 1'b1;
        pop_wid   = NW_WIDTH'(w);
        cyc();
        idle();
    endtask

    task automatic check_rsp(input string tag, input int w, input logic [WIDTH-1:0] d, input logic idx);
        check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
        check({tag, "_wid"},   64'(rsp_wid),   64'(w));
        check({tag, "_data"},  64'(rsp_data),  64'(d));
        check({tag, "_idx"},   64'(rsp_idx),   64'(idx));
        $display("pop rsp %s: wid=%0d data=%0h idx=%0d", tag, rsp_wid, rsp_data, rsp_idx);
    endtask

    function automatic logic [CNTW-1:0] cnt(input int w);
        return count[w*CNTW +: CNTW];
    endfunction

    initial begin
        reset = 1'b1;
        push_wid = '0; push_data = '0; pop_wid = '0; flush_wid = '0;
        idle();
        cyc(); cyc();
        reset = 1'b0;
        check("rst_count", 64'(count), 64'(0));
        check("rst_empty", 64'(empty), 64'hF);
        check("rst_full", 64'(full), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_errs", 64'({err_overflow, err_underflow, err_conflict}), 64'(0));
        $display("reset: count=%0h empty=%0h", count, empty);

        // Split/join ordering on warp 2
        do_push(2, 32'h100);
        do_push(2, 32'h200);
        check("w2_count2", 64'(cnt(2)), 64'(2));
        check("w2_empty", 64'(empty), 64'b1011);
        pop_valid = 1'b1; pop_wid = 2'd2;
        cyc(); check_rsp("w2_p1", 2, 32'h200, 1'b0); check("w2_cnt_p1", 64'(cnt(2)), 64'(2));
        cyc(); check_rsp("w2_p2", 2, 32'h200, 1'b1); check("w2_cnt_p2", 64'(cnt(2)), 64'(1));
        cyc(); check_rsp("w2_p3", 2, 32'h100, 1'b0);
        cyc(); check_rsp("w2_p4", 2, 32'h100, 1'b1);
        idle();
        check("w2_count0", 64'(cnt(2)), 64'(0));
        check("w2_empty1", 64'(empty[2]), 64'(1));
        cyc();
        check("w2_rsp_idle", 64'(rsp_valid), 64'(0));

        // Fill warp 0, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            do_push(0, 32'h10 + 32'(i));
            $display("push w0 data=%0h count=%0d", 32'h10 + i, cnt(0));
        end
        check("w0_full", 64'(full[0]), 64'(1));
        check("w0_ovf_clear", 64'(err_overflow), 64'(0));
        do_push(0, 32'hDEAD);
        check("w0_ovf", 64'(err_overflow), 64'(1));
        check("w0_cnt8", 64'(cnt(0)), 64'(8));
        do_pop(0);
        check_rsp("w0_top", 0, 32'h17, 1'b0);
        flush_valid = 1'b1; flush_wid = 2'd0;
        cyc(); idle();
        check("w0_flushed", 64'(cnt(0)), 64'(0));
        check("w0_flush_rsp", 64'(rsp_valid), 64'(0));

        // Push warp 1 and pop warp 3 in the same cycle
        do_push(3, 32'h33);
        push_valid = 1'b1; push_wid = 2'd1; push_data = 32'hAA;
        pop_valid = 1'b1; pop_wid = 2'd3;
        cyc(); idle();
        check_rsp("dual", 3, 32'h33, 1'b0);
        check("dual_cnt1", 64'(cnt(1)), 64'(1));
        check("dual_cnt3", 64'(cnt(3)), 64'(1));
        check("dual_no_conflict", 64'(err_conflict), 64'(0));

        // Same-warp push and pop: push wins
        do_push(0, 32'h55);
        push_valid = 1'b1; push_wid = 2'd0; push_data = 32'h66;
        pop_valid = 1'b1; pop_wid = 2'd0;
        cyc(); idle();
        check("conf_cnt0", 64'(cnt(0)), 64'(2));
        check("conf_rsp", 64'(rsp_valid), 64'(0));
        check("conf_err", 64'(err_conflict), 64'(1));
        $display("conflict: count0=%0d err_conflict=%0d", cnt(0), err_conflict);

        // Flush warp 1 together with a pop on warp 1
        do_push(1, 32'hBB);
        do_push(1, 32'hCC);
        do_push(2, 32'h222);
        check("fl_pre_cnt1", 64'(cnt(1)), 64'(3));
        flush_valid = 1'b1; flush_wid = 2'd1;
        pop_valid = 1'b1; pop_wid = 2'd1;
        cyc(); idle();
        check("fl_cnt1", 64'(cnt(1)), 64'(0));
        check("fl_rsp", 64'(rsp_valid), 64'(0));
        check("fl_errs", 64'({err_overflow, err_underflow, err_conflict}), 64'b101);
        check("fl_cnt2", 64'(cnt(2)), 64'(1));
        do_pop(2);
        check_rsp("fl_w2", 2, 32'h222, 1'b0);

        // Drain warp 3 then underflow it
        do_pop(3);
        check_rsp("w3_join", 3, 32'h33, 1'b1);
        check("w3_empty", 64'(empty[3]), 64'(1));
        do_pop(3);
        check("unf_rsp", 64'(rsp_valid), 64'(0));
        check("unf_err", 64'(err_underflow), 64'(1));

        // Reset while a pop response is in flight
        pop_valid = 1'b1; pop_wid = 2'd2;
        reset = 1'b1;
        cyc(); idle();
        reset = 1'b0;
        check("rst2_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst2_errs", 64'({err_overflow, err_underflow, err_conflict}), 64'(0));
        check("rst2_count", 64'(count), 64'(0));
        check("rst2_empty", 64'(empty), 64'hF);
        $display("reset2: rsp_valid=%0d count=%0h", rsp_valid, count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
